// File: rtl/gate_response_checker.sv
// Stimulus/response checker for single-input gates (NOT or buffer cells).
// Drives a vector sequence, samples the gate output, counts mismatches and reports the first failure.
module gate_response_checker #(
    parameter int NUM_VECTORS = 8,
    parameter int SETTLE      = 2,
    parameter int INVERT      = 1,
    parameter int PATTERN     = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp,
    output logic             stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       vec_idx,
    output logic             first_fail_valid,
    output logic [7:0]       first_fail_idx
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int         SCW       = $clog2(SETTLE + 1);
    localparam logic [3:0] LFSR_SEED = 4'b1001;
    localparam logic [7:0] LAST_IDX  = 8'(NUM_VECTORS - 1);

    logic [1:0]     state;
    logic [3:0]     lfsr;
    logic [3:0]     lfsr_next;
    logic [SCW-1:0] settle_cnt;
    logic           expected;
    logic           mismatch;
    logic           err_sat;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign expected  = (INVERT != 0) ? ~stim : stim;
    assign mismatch  = (resp != expected);
    assign err_sat   = (err_count == {CNT_W{1'b1}});
    // x^4+x^3+1, shifting left with the feedback entering bit 0.
    assign lfsr_next = {lfsr[2:0], lfsr[3] ^ lfsr[2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            stim             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            vec_idx          <= 8'd0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 8'd0;
            lfsr             <= LFSR_SEED;
            settle_cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state            <= S_DRIVE;
                        vec_idx          <= 8'd0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_idx   <= 8'd0;
                        pass             <= 1'b0;
                        settle_cnt       <= '0;
                        lfsr             <= LFSR_SEED;
                        stim             <= (PATTERN != 0) ? LFSR_SEED[0] : 1'b1;
                    end
                end
                S_DRIVE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SCW'(SETTLE - 1)) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        if (!err_sat) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_idx   <= vec_idx;
                        end
                    end
                    if (vec_idx == LAST_IDX) begin
                        state <= S_DONE;
                        // NOTE: err_count still holds the pre-sample value here, so the
                        // final vector's result is folded in explicitly.
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        state      <= S_DRIVE;
                        vec_idx    <= vec_idx + 8'd1;
                        settle_cnt <= '0;
                        if (PATTERN != 0) begin
                            lfsr <= lfsr_next;
                            stim <= lfsr_next[0];
                        end else begin
                            stim <= ~stim;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
